// File: rtl/online_otf_converter_if.sv
// Handshake bundle between the online multiplier output, the signed-digit converter and its consumer.
interface online_otf_converter_if #(
    parameter int NDIG = 10
);
    logic                in_valid;
    logic                in_ready;
    logic [2*NDIG-1:0]   din;
    logic                out_valid;
    logic                out_ready;
    logic [NDIG:0]       dout;
    logic                busy;

    modport master (
        output in_valid, din, out_ready,
        input  in_ready, out_valid, dout, busy
    );

    modport slave (
        input  in_valid, din, out_ready,
        output in_ready, out_valid, dout, busy
    );
endinterface

// File: rtl/online_otf_converter.sv
// MSD-first on-the-fly conversion of a radix-2 signed-digit word {pos,neg} into two's complement.
module online_otf_converter #(
    parameter int NDIG = 10
) (
    input logic                  clk,
    input logic                  rst,
    online_otf_converter_if.slave bus
);

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state;
    logic [2*NDIG-1:0]   shreg;
    logic [NDIG:0]       q;
    logic [NDIG:0]       qm;
    logic [CW-1:0]       cnt;
    logic                out_valid_r;
    logic [NDIG:0]       dout_r;

    logic [1:0]          msd;
    logic [NDIG:0]       q_step;
    logic [NDIG:0]       qm_step;
    logic                in_ready_c;

    assign msd = shreg[2*NDIG-1:2*NDIG-2];

    // Q tracks the value so far, QM = Q-1; a -1 digit borrows by switching to the QM branch.
    always_comb begin
        q_step  = {q[NDIG-1:0], 1'b0};
        qm_step = {qm[NDIG-1:0], 1'b1};
        case (msd)
            2'b10: begin
                q_step  = {q[NDIG-1:0], 1'b1};
                qm_step = {q[NDIG-1:0], 1'b0};
            end
            2'b01: begin
                q_step  = {qm[NDIG-1:0], 1'b1};
                qm_step = {qm[NDIG-1:0], 1'b0};
            end
            default: begin
                q_step  = {q[NDIG-1:0], 1'b0};
                qm_step = {qm[NDIG-1:0], 1'b1};
            end
        endcase
    end

    // A finished result may drain in the same cycle a new word is taken.
    always_comb begin
        in_ready_c = 1'b0;
        case (state)
            IDLE:    in_ready_c = 1'b1;
            DONE:    in_ready_c = bus.out_ready;
            default: in_ready_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            q           <= '0;
            qm          <= '1;
            cnt         <= '0;
            out_valid_r <= 1'b0;
            dout_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg <= bus.din;
                        q     <= '0;
                        qm    <= '1;
                        cnt   <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    shreg <= {shreg[2*NDIG-3:0], 2'b00};
                    q     <= q_step;
                    qm    <= qm_step;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NDIG - 1)) begin
                        dout_r      <= q_step;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (bus.in_valid) begin
                            shreg <= bus.din;
                            q     <= '0;
                            qm    <= '1;
                            cnt   <= '0;
                            state <= CONV;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.dout      = dout_r;
    assign bus.busy      = (state == CONV);

endmodule

// File: tb/tb_online_otf_converter.sv
// Directed bench for the signed-digit to two's-complement converter with NDIG=10.
module tb_online_otf_converter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    online_otf_converter_if #(.NDIG(10)) bus ();

    online_otf_converter #(.NDIG(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present a word, confirm it is taken, then count edges until the result shows up.
    task automatic applyStimulus(input string tag, input logic [19:0] word, input logic [10:0] expected);
        int n;
        @(negedge clk);
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.din      = word;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.din      = ~word;
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'd10);
        checkOutput({tag, "_dout"}, 32'(bus.dout), 32'(expected));
    endtask

    task automatic drainResult(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_dout", 32'(bus.dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("zero", 20'h00000, 11'h000);
        drainResult("zero");
        applyStimulus("x41", 20'h02142, 11'h029);
        drainResult("x41");
        applyStimulus("all_neg", 20'h55555, 11'h401);
        drainResult("all_neg");
        applyStimulus("all_pos", 20'hAAAAA, 11'h3FF);
        drainResult("all_pos");
        applyStimulus("all_11", 20'hFFFFF, 11'h000);
        drainResult("all_11");
        applyStimulus("msd_pos", 20'h80000, 11'h200);
        drainResult("msd_pos");
        applyStimulus("msd_neg", 20'h40000, 11'h600);
        drainResult("msd_neg");

        // Backpressure: result held while a competing word is offered.
        applyStimulus("bp", 20'h02142, 11'h029);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.din      = 20'hAAAAA;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_dout", 32'(bus.dout), 32'h029);
            checkOutput("bp_busy", 32'(bus.busy), 32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("bp_drain_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_idle_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("bp_idle_busy", 32'(bus.busy), 32'd0);

        // Back-to-back: drain and accept on the same edge.
        applyStimulus("b2b_first", 20'hAAAAA, 11'h3FF);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.din       = 20'h55555;
        #1;
        checkOutput("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.din       = 20'h00000;
        checkOutput("b2b_out_valid_cleared", 32'(bus.out_valid), 32'd0);
        checkOutput("b2b_busy", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b2b_latency", 32'(n), 32'd10);
        checkOutput("b2b_dout", 32'(bus.dout), 32'h401);
        drainResult("b2b");

        // Abort: reset lands on the 4th conversion edge.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.din      = 20'h02142;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_dout", 32'(bus.dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        checkOutput("abort_no_result", 32'(seen), 32'd0);

        applyStimulus("after_abort", 20'h40000, 11'h600);
        drainResult("after_abort");

        $display("[TB] directed sequence complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
